// File: rtl/fifo_pack_flush.sv
`default_nettype none
// ============================================================================
// Module   : fifo_pack_flush
// Purpose  : Packing FIFO. It collects PACK narrow IN_W-bit beats (lane 0
//            first) into one OUT_W-bit row and stores up to DEPTH rows.
//            Both sides use ready/valid handshakes. A flush request pads
//            the partial row with PAD_VAL lanes and commits it. The FIFO
//            then drains every committed row and pulses flush_done_o.
// Ports    : clk, reset (async, active-low)
//            wr_valid_i / wr_data_i / wr_ready_o  - narrow write side
//            rd_valid_o / rd_data_o / rd_ready_i  - wide read side
//            flush_i, flush_busy_o, flush_done_o  - flush control
//            level_o, empty_o, full_o             - occupancy status
//            rd_lane_vld_o (FIFO_PACK_LANE_MASK_EN only) - per-lane written mask
// Options  : define FIFO_PACK_LANE_MASK_EN to add the per-row lane mask.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_pack_flush #(
  parameter int              IN_W    = 4,
  parameter int              PACK    = 8,
  parameter int              DEPTH   = 4,
  parameter logic [IN_W-1:0] PAD_VAL = IN_W'(4'hC),
  localparam int             OUT_W   = IN_W * PACK,
  localparam int             LW      = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_valid_i,
  input  logic [IN_W-1:0]  wr_data_i,
  output logic             wr_ready_o,
  output logic             rd_valid_o,
  input  logic             rd_ready_i,
  output logic [OUT_W-1:0] rd_data_o,
  input  logic             flush_i,
  output logic             flush_busy_o,
  output logic             flush_done_o,
  output logic [LW-1:0]    level_o,
  output logic             empty_o,
  output logic             full_o
`ifdef FIFO_PACK_LANE_MASK_EN
  ,
  output logic [PACK-1:0]  rd_lane_vld_o
`endif
);

  localparam int CW = (PACK > 1) ? $clog2(PACK) : 1;
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   col_q, col_d, col_after;
  logic [AW-1:0]   wr_row_q, wr_row_d, rd_row_q, rd_row_d;
  logic [LW-1:0]   level_q, level_d, drain_q, drain_d;
  logic [OUT_W-1:0] mem_q [DEPTH];

  logic            wr_fire, rd_fire, flush_go, row_done, pad, commit;
  logic [PACK-1:0] lane_data_we, lane_pad_we;

  assign full_o       = (level_q == LW'(DEPTH));
  assign empty_o      = (level_q == '0) && (col_q == '0);
  assign level_o      = level_q;
  assign wr_ready_o   = !full_o && (state_q == ST_IDLE);
  assign rd_valid_o   = (level_q != '0);
  assign rd_data_o    = mem_q[rd_row_q];
  assign flush_busy_o = (state_q != ST_IDLE);

  assign wr_fire  = wr_valid_i && wr_ready_o;
  assign rd_fire  = rd_valid_o && rd_ready_i;
  assign flush_go = flush_i && (state_q == ST_IDLE);
  assign row_done = wr_fire && (col_q == CW'(PACK - 1));

  // Column position once any same-cycle beat has landed; the pad decision
  // looks at this so a beat that completes the row suppresses padding.
  assign col_after = wr_fire ? (row_done ? '0 : col_q + 1'b1) : col_q;
  assign pad       = flush_go && (col_after != '0);
  assign commit    = row_done || pad;

  // Per-lane write enables: the data beat goes into lane col_q, and padding
  // fills every lane from col_after upwards. The two ranges never overlap.
  for (genvar l = 0; l < PACK; l++) begin : g_lane
    assign lane_data_we[l] = wr_fire && (col_q == CW'(l));
    assign lane_pad_we[l]  = pad && (CW'(l) >= col_after);
  end

  always_comb begin
    col_d    = pad ? '0 : col_after;
    wr_row_d = commit  ? wr_row_q + 1'b1 : wr_row_q;
    rd_row_d = rd_fire ? rd_row_q + 1'b1 : rd_row_q;
    level_d  = level_q + LW'(commit) - LW'(rd_fire);
  end

  always_comb begin
    state_d      = state_q;
    drain_d      = drain_q;
    flush_done_o = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (flush_go) begin
          state_d = ST_DRAIN;
          drain_d = level_d;   // already includes the pad commit and any read
        end
      end
      ST_DRAIN: begin
        if (rd_fire) drain_d = drain_q - 1'b1;
        if ((drain_q == '0) || (rd_fire && (drain_q == LW'(1)))) state_d = ST_DONE;
      end
      ST_DONE: begin
        flush_done_o = 1'b1;
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      col_q    <= '0;
      wr_row_q <= '0;
      rd_row_q <= '0;
      level_q  <= '0;
      drain_q  <= '0;
    end else begin
      state_q  <= state_d;
      col_q    <= col_d;
      wr_row_q <= wr_row_d;
      rd_row_q <= rd_row_d;
      level_q  <= level_d;
      drain_q  <= drain_d;
    end
  end

  // Row storage is deliberately left without reset.
  always_ff @(posedge clk) begin
    for (int l = 0; l < PACK; l++) begin
      if (lane_data_we[l])
        mem_q[wr_row_q][l*IN_W +: IN_W] <= wr_data_i;
      else if (lane_pad_we[l])
        mem_q[wr_row_q][l*IN_W +: IN_W] <= PAD_VAL;
    end
  end

`ifdef FIFO_PACK_LANE_MASK_EN
  logic [PACK-1:0] mask_q [DEPTH];

  always_ff @(posedge clk) begin
    for (int l = 0; l < PACK; l++) begin
      if (lane_data_we[l] || lane_pad_we[l])
        mask_q[wr_row_q][l] <= lane_data_we[l];
    end
  end

  assign rd_lane_vld_o = mask_q[rd_row_q];
`endif

endmodule
`default_nettype wire

// File: tb/tb_fifo_pack_flush.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_pack_flush
// Purpose  : Self-checking bench for fifo_pack_flush (default parameters).
//            A queue-based reference model holds completed rows and
//            partial beats.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_pack_flush;

  localparam int IN_W  = 4;
  localparam int PACK  = 8;
  localparam int DEPTH = 4;
  localparam int OUT_W = IN_W * PACK;
  localparam int LW    = $clog2(DEPTH) + 1;
  localparam logic [IN_W-1:0] PAD = 4'hC;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             wr_valid_i = 1'b0;
  logic [IN_W-1:0]  wr_data_i = '0;
  logic             wr_ready_o;
  logic             rd_valid_o;
  logic             rd_ready_i = 1'b0;
  logic [OUT_W-1:0] rd_data_o;
  logic             flush_i = 1'b0;
  logic             flush_busy_o, flush_done_o;
  logic [LW-1:0]    level_o;
  logic             empty_o, full_o;
`ifdef FIFO_PACK_LANE_MASK_EN
  logic [PACK-1:0]  rd_lane_vld_o;
`endif

  fifo_pack_flush dut (
    .clk          (clk),
    .reset        (reset),
    .wr_valid_i   (wr_valid_i),
    .wr_data_i    (wr_data_i),
    .wr_ready_o   (wr_ready_o),
    .rd_valid_o   (rd_valid_o),
    .rd_ready_i   (rd_ready_i),
    .rd_data_o    (rd_data_o),
    .flush_i      (flush_i),
    .flush_busy_o (flush_busy_o),
    .flush_done_o (flush_done_o),
    .level_o      (level_o),
    .empty_o      (empty_o),
    .full_o       (full_o)
`ifdef FIFO_PACK_LANE_MASK_EN
    ,
    .rd_lane_vld_o(rd_lane_vld_o)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: committed rows, their lane masks, pending beats, and a
  // flush phase (0 idle, 1 draining, 2 done) with rows left to drain.
  logic [OUT_W-1:0] rows  [$];
  logic [PACK-1:0]  masks [$];
  logic [IN_W-1:0]  part  [$];
  int               mst    = 0;
  int               mdrain = 0;

  task automatic model_clear();
    rows.delete(); masks.delete(); part.delete();
    mst = 0; mdrain = 0;
  endtask

  task automatic commit_part();
    logic [OUT_W-1:0] row;
    logic [PACK-1:0]  m;
    logic [IN_W-1:0]  lane;
    row = '0; m = '0;
    for (int i = 0; i < PACK; i++) begin
      lane = (i < part.size()) ? part[i] : PAD;
      row  = row | (OUT_W'(lane) << (i * IN_W));
      m[i] = (i < part.size());
    end
    rows.push_back(row);
    masks.push_back(m);
    part.delete();
  endtask

  task automatic model_step(input logic wv, input logic [IN_W-1:0] wd,
                            input logic rr, input logic fl);
    bit ready, acc, rd;
    ready = (rows.size() < DEPTH) && (mst == 0);
    acc   = wv && ready;
    rd    = rr && (rows.size() > 0);
    if (rd) begin
      void'(rows.pop_front());
      void'(masks.pop_front());
    end
    if (acc) begin
      part.push_back(wd);
      if (part.size() == PACK) commit_part();
    end
    case (mst)
      0: if (fl) begin
           if (part.size() > 0) commit_part();
           mdrain = rows.size();
           mst    = 1;
         end
      1: begin
           if (rd) mdrain--;
           if (mdrain <= 0) mst = 2;
         end
      default: mst = 0;
    endcase
  endtask

  // One clock: drive inputs, advance the model, sample 1 ns after the edge.
  task automatic cycle(input logic wv, input logic [IN_W-1:0] wd,
                       input logic rr, input logic fl);
    wr_valid_i = wv; wr_data_i = wd; rd_ready_i = rr; flush_i = fl;
    model_step(wv, wd, rr, fl);
    @(posedge clk); #1;
    wr_valid_i = 1'b0; rd_ready_i = 1'b0; flush_i = 1'b0;
  endtask

  task automatic do_reset();
    wr_valid_i = 1'b0; rd_ready_i = 1'b0; flush_i = 1'b0;
    @(negedge clk); reset = 1'b0; model_clear();
    @(posedge clk); #1;
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (wr_ready_o !== 1'b1)   begin n_fail++; $display("FAIL reset_wr_ready got %b exp 1", wr_ready_o); end
    n_checks++; if (rd_valid_o !== 1'b0)   begin n_fail++; $display("FAIL reset_rd_valid got %b exp 0", rd_valid_o); end
    n_checks++; if (flush_busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", flush_busy_o); end
    n_checks++; if (flush_done_o !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b exp 0", flush_done_o); end
    n_checks++; if (level_o !== '0)        begin n_fail++; $display("FAIL reset_level got %0d exp 0", level_o); end
    n_checks++; if (empty_o !== 1'b1)      begin n_fail++; $display("FAIL reset_empty got %b exp 1", empty_o); end
    n_checks++; if (full_o !== 1'b0)       begin n_fail++; $display("FAIL reset_full got %b exp 0", full_o); end
  endtask

  task automatic test_pack();
    do_reset();
    for (int i = 1; i <= 8; i++) begin
      cycle(1'b1, IN_W'(i), 1'b0, 1'b0);
      if (i == 7) begin
        n_checks++; if (rd_valid_o !== 1'b0) begin n_fail++; $display("FAIL pack_early_valid got %b exp 0", rd_valid_o); end
        n_checks++; if (empty_o !== 1'b0)    begin n_fail++; $display("FAIL pack_partial_empty got %b exp 0", empty_o); end
      end
    end
    n_checks++; if (rd_valid_o !== 1'b1)       begin n_fail++; $display("FAIL pack_valid got %b exp 1", rd_valid_o); end
    n_checks++; if (rd_data_o !== 32'h87654321) begin n_fail++; $display("FAIL pack_data got %h exp 87654321", rd_data_o); end
    n_checks++; if (level_o !== LW'(1))         begin n_fail++; $display("FAIL pack_level got %0d exp 1", level_o); end
    n_checks++; if (empty_o !== 1'b0)           begin n_fail++; $display("FAIL pack_empty got %b exp 0", empty_o); end
`ifdef FIFO_PACK_LANE_MASK_EN
    n_checks++; if (rd_lane_vld_o !== 8'hFF)    begin n_fail++; $display("FAIL pack_mask got %h exp ff", rd_lane_vld_o); end
`endif
    cycle(1'b0, '0, 1'b1, 1'b0);
    n_checks++; if (empty_o !== 1'b1)           begin n_fail++; $display("FAIL pack_drained_empty got %b exp 1", empty_o); end
  endtask

  task automatic test_flush_partial();
    do_reset();
    cycle(1'b1, 4'hA, 1'b0, 1'b0);
    cycle(1'b1, 4'hB, 1'b0, 1'b0);
    cycle(1'b1, 4'hD, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b1);
    n_checks++; if (rd_data_o !== 32'hCCCCCDBA) begin n_fail++; $display("FAIL fpart_data got %h exp cccccdba", rd_data_o); end
    n_checks++; if (level_o !== LW'(1))         begin n_fail++; $display("FAIL fpart_level got %0d exp 1", level_o); end
    n_checks++; if (flush_busy_o !== 1'b1)      begin n_fail++; $display("FAIL fpart_busy got %b exp 1", flush_busy_o); end
    n_checks++; if (wr_ready_o !== 1'b0)        begin n_fail++; $display("FAIL fpart_wr_ready got %b exp 0", wr_ready_o); end
`ifdef FIFO_PACK_LANE_MASK_EN
    n_checks++; if (rd_lane_vld_o !== 8'h07)    begin n_fail++; $display("FAIL fpart_mask got %h exp 07", rd_lane_vld_o); end
`endif
    cycle(1'b0, '0, 1'b1, 1'b0);
    n_checks++; if (flush_done_o !== 1'b1)      begin n_fail++; $display("FAIL fpart_done got %b exp 1", flush_done_o); end
    cycle(1'b0, '0, 1'b0, 1'b0);
    n_checks++; if (flush_done_o !== 1'b0)      begin n_fail++; $display("FAIL fpart_done_len got %b exp 0", flush_done_o); end
    n_checks++; if (empty_o !== 1'b1)           begin n_fail++; $display("FAIL fpart_empty got %b exp 1", empty_o); end
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 0; i < 32; i++) cycle(1'b1, IN_W'(i), 1'b0, 1'b0);
    n_checks++; if (full_o !== 1'b1)     begin n_fail++; $display("FAIL full_flag got %b exp 1", full_o); end
    n_checks++; if (wr_ready_o !== 1'b0) begin n_fail++; $display("FAIL full_wr_ready got %b exp 0", wr_ready_o); end
    n_checks++; if (level_o !== LW'(4))  begin n_fail++; $display("FAIL full_level got %0d exp 4", level_o); end
    cycle(1'b1, 4'h5, 1'b0, 1'b0);
    n_checks++; if (level_o !== LW'(4))  begin n_fail++; $display("FAIL full_drop_level got %0d exp 4", level_o); end
    n_checks++; if (rd_data_o !== 32'h76543210) begin n_fail++; $display("FAIL full_head got %h exp 76543210", rd_data_o); end
    cycle(1'b0, '0, 1'b1, 1'b0);
    n_checks++; if (wr_ready_o !== 1'b1) begin n_fail++; $display("FAIL full_read_ready got %b exp 1", wr_ready_o); end
    n_checks++; if (level_o !== LW'(3))  begin n_fail++; $display("FAIL full_read_level got %0d exp 3", level_o); end
    n_checks++; if (rd_data_o !== 32'hFEDCBA98) begin n_fail++; $display("FAIL full_next_head got %h exp fedcba98", rd_data_o); end
    for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b1, 1'b0);
    n_checks++; if (empty_o !== 1'b1)    begin n_fail++; $display("FAIL full_drained got %b exp 1", empty_o); end
  endtask

  task automatic test_flush_empty();
    do_reset();
    cycle(1'b0, '0, 1'b0, 1'b1);
    n_checks++; if (flush_busy_o !== 1'b1) begin n_fail++; $display("FAIL fempty_busy1 got %b exp 1", flush_busy_o); end
    n_checks++; if (flush_done_o !== 1'b0) begin n_fail++; $display("FAIL fempty_done1 got %b exp 0", flush_done_o); end
    cycle(1'b0, '0, 1'b1, 1'b0);
    n_checks++; if (flush_busy_o !== 1'b1) begin n_fail++; $display("FAIL fempty_busy2 got %b exp 1", flush_busy_o); end
    n_checks++; if (flush_done_o !== 1'b1) begin n_fail++; $display("FAIL fempty_done2 got %b exp 1", flush_done_o); end
    n_checks++; if (rd_valid_o !== 1'b0)   begin n_fail++; $display("FAIL fempty_valid got %b exp 0", rd_valid_o); end
    cycle(1'b0, '0, 1'b0, 1'b0);
    n_checks++; if (flush_busy_o !== 1'b0) begin n_fail++; $display("FAIL fempty_busy3 got %b exp 0", flush_busy_o); end
    n_checks++; if (flush_done_o !== 1'b0) begin n_fail++; $display("FAIL fempty_done3 got %b exp 0", flush_done_o); end
  endtask

  task automatic test_flush_with_last();
    do_reset();
    for (int i = 1; i <= 7; i++) cycle(1'b1, IN_W'(i), 1'b0, 1'b0);
    cycle(1'b1, 4'h8, 1'b0, 1'b1);
    n_checks++; if (level_o !== LW'(1))          begin n_fail++; $display("FAIL flast_level got %0d exp 1", level_o); end
    n_checks++; if (rd_data_o !== 32'h87654321)  begin n_fail++; $display("FAIL flast_data got %h exp 87654321", rd_data_o); end
    n_checks++; if (flush_busy_o !== 1'b1)       begin n_fail++; $display("FAIL flast_busy got %b exp 1", flush_busy_o); end
    cycle(1'b0, '0, 1'b1, 1'b0);
    n_checks++; if (flush_done_o !== 1'b1)       begin n_fail++; $display("FAIL flast_done got %b exp 1", flush_done_o); end
    n_checks++; if (level_o !== LW'(0))          begin n_fail++; $display("FAIL flast_level2 got %0d exp 0", level_o); end
    cycle(1'b0, '0, 1'b0, 1'b0);
    n_checks++; if (flush_busy_o !== 1'b0)       begin n_fail++; $display("FAIL flast_idle got %b exp 0", flush_busy_o); end
  endtask

  task automatic test_reset_mid_flush();
    bit seen_done;
    do_reset();
    for (int i = 0; i < 16; i++) cycle(1'b1, IN_W'(i), 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b1);
    n_checks++; if (level_o !== LW'(2)) begin n_fail++; $display("FAIL rmid_pending got %0d exp 2", level_o); end
    #2 reset = 1'b0;
    model_clear();
    #1;
    n_checks++; if (flush_busy_o !== 1'b0) begin n_fail++; $display("FAIL rmid_busy got %b exp 0", flush_busy_o); end
    n_checks++; if (level_o !== '0)        begin n_fail++; $display("FAIL rmid_level got %0d exp 0", level_o); end
    n_checks++; if (rd_valid_o !== 1'b0)   begin n_fail++; $display("FAIL rmid_valid got %b exp 0", rd_valid_o); end
    n_checks++; if (wr_ready_o !== 1'b1)   begin n_fail++; $display("FAIL rmid_ready got %b exp 1", wr_ready_o); end
    n_checks++; if (empty_o !== 1'b1)      begin n_fail++; $display("FAIL rmid_empty got %b exp 1", empty_o); end
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    seen_done = flush_done_o;
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, IN_W'(i + 9), 1'b0, 1'b0);
      seen_done = seen_done | flush_done_o;
    end
    n_checks++; if (seen_done !== 1'b0)         begin n_fail++; $display("FAIL rmid_done_pulse got %b exp 0", seen_done); end
    n_checks++; if (rd_data_o !== 32'h0FEDCBA9) begin n_fail++; $display("FAIL rmid_repack got %h exp 0fedcba9", rd_data_o); end
    n_checks++; if (level_o !== LW'(1))         begin n_fail++; $display("FAIL rmid_level2 got %0d exp 1", level_o); end
  endtask

  task automatic test_random();
    logic wv, rr, fl;
    logic [IN_W-1:0] wd;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      wv = 1'($urandom_range(0, 3) != 0);
      wd = IN_W'($urandom);
      rr = 1'($urandom_range(0, 2) == 0);
      fl = 1'($urandom_range(0, 24) == 0);
      cycle(wv, wd, rr, fl);
      n_checks++; if (level_o !== LW'(rows.size())) begin n_fail++; $display("FAIL rnd_level cyc %0d got %0d exp %0d", c, level_o, rows.size()); end
      n_checks++; if (rd_valid_o !== (rows.size() > 0)) begin n_fail++; $display("FAIL rnd_valid cyc %0d got %b", c, rd_valid_o); end
      n_checks++; if (empty_o !== (rows.size() == 0 && part.size() == 0)) begin n_fail++; $display("FAIL rnd_empty cyc %0d got %b", c, empty_o); end
      n_checks++; if (full_o !== (rows.size() == DEPTH)) begin n_fail++; $display("FAIL rnd_full cyc %0d got %b", c, full_o); end
      n_checks++; if (wr_ready_o !== (rows.size() < DEPTH && mst == 0)) begin n_fail++; $display("FAIL rnd_ready cyc %0d got %b", c, wr_ready_o); end
      n_checks++; if (flush_busy_o !== (mst != 0)) begin n_fail++; $display("FAIL rnd_busy cyc %0d got %b exp phase %0d", c, flush_busy_o, mst); end
      n_checks++; if (flush_done_o !== (mst == 2)) begin n_fail++; $display("FAIL rnd_done cyc %0d got %b exp phase %0d", c, flush_done_o, mst); end
      if (rows.size() > 0) begin
        n_checks++; if (rd_data_o !== rows[0]) begin n_fail++; $display("FAIL rnd_data cyc %0d got %h exp %h", c, rd_data_o, rows[0]); end
`ifdef FIFO_PACK_LANE_MASK_EN
        n_checks++; if (rd_lane_vld_o !== masks[0]) begin n_fail++; $display("FAIL rnd_mask cyc %0d got %h exp %h", c, rd_lane_vld_o, masks[0]); end
`endif
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_pack();
    test_flush_partial();
    test_full();
    test_flush_empty();
    test_flush_with_last();
    test_reset_mid_flush();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
